// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU time-sharing controller: ALU op codes,
// sequencer state encoding and the round-robin pointer helper.
package alu_share_ctrl_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or
// after the pointer, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    always_comb begin
        int  j;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && valid[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external combinational ALU between NREQ requesters using a
// round-robin grant and an IDLE -> EXEC -> RESP sequencer.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ALU_W,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_zero,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [2:0]        alu_op,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic [15:0]       op_count
);

    state_e           state;
    logic [IDW-1:0]   ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             owner_ready;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Accept only in IDLE; the response lane is decoded from the owner index.
    assign req_ready   = (state == ST_IDLE) ? grant : '0;
    assign rsp_valid   = (state == ST_RESP) ? (NREQ'(1) << rsp_id) : '0;
    assign busy        = (state != ST_IDLE);
    assign owner_ready = rsp_ready[rsp_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        alu_a  <= req_a[int'(grant_idx)*W +: W];
                        alu_b  <= req_b[int'(grant_idx)*W +: W];
                        alu_op <= req_op[int'(grant_idx)*3 +: 3];
                        rsp_id <= grant_idx;
                        ptr    <= IDW'(rr_next(int'(grant_idx), NREQ));
                        state  <= ST_EXEC;
                    end
                end
                // ALU inputs settled during this cycle; capture its outputs.
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner_ready) begin
                        op_count <= op_count + 16'd1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
